mem_dma: RTL and testbench
==========================

Name: mem_dma

Overview:
- Block-transfer engine placed directly upstream of the processor data memory (simple dual-port RAM: one write port, one registered read port with 1-cycle read latency).
- Owns the memory's write and read ports. In IDLE it passes the processor's load/store signals straight through.
- When started, it moves a contiguous block between the memory and a valid/ready stream:
  - WRITE direction: stream-in to memory.
  - READ direction: memory to stream-out.
- While a transfer runs, the processor is held off with a busy flag.

Parameters:
- NADDRE, 8, number of memory words; address width AW = $clog2(NADDRE).
- NBDATA, 32, data word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_wr  in  1  processor store strobe.
- cpu_addr_w  in  AW  processor store address.
- cpu_addr_r  in  AW  processor load address.
- cpu_data_in  in  NBDATA  processor store data.
- cpu_busy  out  1  high while a transfer is active; processor access is ignored.
- start  in  1  one-cycle transfer request, sampled only in IDLE.
- dir  in  1  0 = WRITE (stream to memory), 1 = READ (memory to stream).
- base  in  AW  first memory address.
- len  in  AW+1  word count, 0..NADDRE.
- done  out  1  one-cycle pulse when the transfer completes.
- s_valid  in  1  stream-in word valid.
- s_data  in  NBDATA  stream-in word.
- s_ready  out  1  stream-in accept.
- m_valid  out  1  stream-out word valid.
- m_data  out  NBDATA  stream-out word.
- m_ready  in  1  stream-out accept.
- mem_wr  out  1  to memory write enable.
- mem_addr_w  out  AW  to memory write address.
- mem_addr_r  out  AW  to memory read address.
- mem_data_in  out  NBDATA  to memory write data.
- mem_data_out  in  NBDATA  from memory read data, valid one cycle after mem_addr_r.

Behaviour:
- States: IDLE, WR, RD, DONE.
- Reset (clk edge with rst = 1):
  - State goes to IDLE.
  - cpu_busy = 0, done = 0, s_ready = 0, m_valid = 0, m_data = 0.
  - Counters, in-flight flag and buffer cleared.
  - A transfer in progress is abandoned. No further memory writes occur.
- IDLE memory ports (combinational pass-through):
  - mem_wr = cpu_wr, mem_addr_w = cpu_addr_w, mem_addr_r = cpu_addr_r, mem_data_in = cpu_data_in.
  - cpu_busy = 0.
- Leaving IDLE on start:
  - Latch base, dir and len.
  - len = 0: go to DONE.
  - Otherwise go to WR (dir = 0) or RD (dir = 1).
  - cpu_busy = 1 from the next cycle until the cycle after DONE.
- Outside IDLE:
  - cpu_* inputs are ignored and mem_wr is driven only by the engine.
  - start is ignored.
- Addressing: the word index i runs 0..len-1; address = (base + i) mod NADDRE, wrapping past NADDRE-1 to 0.
- WR state:
  - s_ready = 1.
  - On s_valid & s_ready: mem_wr = 1, mem_addr_w = current address, mem_data_in = s_data, i increments.
  - The accept of word len-1 moves to DONE, with s_ready = 0 from the next cycle.
  - In WR, mem_addr_r holds cpu_addr_r.
- RD state, read issue:
  - 2-entry output buffer; cnt = words held in the buffer plus a read in flight.
  - A read is issued when i < len and cnt < 2 (counting this cycle's pop): mem_addr_r = address, in-flight flag set.
  - The returned mem_data_out is pushed into the buffer on the next cycle.
- RD state, stream-out:
  - m_valid = buffer not empty; m_data = head entry, registered.
  - A pop occurs on m_valid & m_ready.
  - With m_ready held high and no stalls: one word per cycle after a 2-cycle initial latency (start edge to first m_valid).
- RD state, completion and backpressure:
  - Move to DONE after the pop of word len-1.
  - m_data holds its value while m_valid = 1 and m_ready = 0. No word is lost or duplicated under arbitrary m_ready patterns.
- DONE state: done = 1 for exactly one cycle, then IDLE.
- Write/read same address: not possible inside one transfer, since each transfer is one direction only. In IDLE the memory itself defines the result (old data).
- Widths: i and the len compare use AW+1 bits; the address sum truncates to AW bits. Handle non-power-of-two NADDRE with an explicit compare-and-subtract.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE/ST_WR/ST_RD/ST_DONE;
  - DIR_WR = 0, DIR_RD = 1;
  - the AW derivation.
- One sub-module, mem_dma_obuf: 2-entry FIFO with valid/ready output and a space indicator that accounts for the in-flight read.

Test Plan:
- Reset in IDLE, then cpu_wr = 1 with addr_w = 3 and data 0x55 → mem_wr = 1, mem_addr_w = 3, mem_data_in = 0x55 on the same cycle, cpu_busy = 0.
- WRITE with base = 6, len = 4, NADDRE = 8, stream words 0xA0..0xA3 back-to-back → memory writes at addresses 6, 7, 0, 1; done pulses one cycle after the last accept; cpu_busy high for 6 cycles.
- READ with base = 2, len = 3 from memory preloaded mem[k] = k + 0x10, m_ready = 1 → m_data sequence 0x12, 0x13, 0x14 on consecutive cycles, first m_valid 2 cycles after start, then done.
- READ with len = 5 and m_ready toggled 1,0,0,1,0,1,1,... → all 5 words exactly once, in order; m_data stable while stalled; at most 2 reads outstanding.
- start with len = 0 → done the next cycle, no mem_wr, no m_valid. start asserted while busy → ignored, the running transfer is unchanged.
- rst asserted mid-WRITE after 2 of 4 words → state IDLE, s_ready = 0, no further mem_wr, cpu pass-through restored next cycle.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the mem_dma block-transfer engine:
// state encoding, transfer direction and address-width derivation.
package mem_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    // Address width for a memory of n words; never narrower than one bit.
    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_dma_obuf.sv
// Two-entry output FIFO for the read direction. The space flag counts a read
// already issued to the memory so the buffer can never be overrun.
module mem_dma_obuf #(
    parameter int NBDATA = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [NBDATA-1:0] push_data,
    input  logic              inflight,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [NBDATA-1:0] m_data,
    output logic              space,
    output logic              pop
);

    logic [1:0]        count_r;
    logic [1:0]        count_nxt_s;
    logic [NBDATA-1:0] head_r;
    logic [NBDATA-1:0] tail_r;
    logic [NBDATA-1:0] head_nxt_s;
    logic [NBDATA-1:0] tail_nxt_s;
    logic              valid_r;
    logic [2:0]        occ_s;

    assign pop     = valid_r & m_ready;
    assign occ_s   = {1'b0, count_r} + {2'b00, inflight} - {2'b00, pop};
    assign space   = (occ_s < 3'd2);
    assign m_valid = valid_r;
    assign m_data  = head_r;

    // Next FIFO contents; the head register doubles as the stream-out data.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case ({push, pop})
            2'b10: begin
                count_nxt_s = count_r + 2'd1;
                if (count_r == 2'd0) begin
                    head_nxt_s = push_data;
                end else begin
                    tail_nxt_s = push_data;
                end
            end
            2'b01: begin
                count_nxt_s = count_r - 2'd1;
                head_nxt_s  = tail_r;
            end
            2'b11: begin
                if (count_r == 2'd2) begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = push_data;
                end else begin
                    head_nxt_s = push_data;
                end
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // FIFO storage and registered valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 2'd0;
            head_r  <= '0;
            tail_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
        end
    end

endmodule

// File: rtl/mem_dma.sv
// Block-transfer engine in front of the data memory: passes processor
// accesses through when idle, otherwise streams a block in or out.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int NADDRE = 8,
    parameter int NBDATA = 32,
    parameter int AW     = aw_of(NADDRE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr,
    input  logic [AW-1:0]     cpu_addr_w,
    input  logic [AW-1:0]     cpu_addr_r,
    input  logic [NBDATA-1:0] cpu_data_in,
    output logic              cpu_busy,
    input  logic              start,
    input  logic              dir,
    input  logic [AW-1:0]     base,
    input  logic [AW:0]       len,
    output logic              done,
    input  logic              s_valid,
    input  logic [NBDATA-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [NBDATA-1:0] m_data,
    input  logic              m_ready,
    output logic              mem_wr,
    output logic [AW-1:0]     mem_addr_w,
    output logic [AW-1:0]     mem_addr_r,
    output logic [NBDATA-1:0] mem_data_in,
    input  logic [NBDATA-1:0] mem_data_out
);

    localparam logic [AW:0]   ONE_W   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW+1:0] NWORDS_W = NADDRE[AW+1:0];

    // (b + idx) mod NADDRE; idx < NADDRE so one conditional subtract suffices.
    function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] b, input logic [AW:0] idx);
        logic [AW+1:0] sum;
        sum = {2'b00, b} + {1'b0, idx};
        if (sum >= NWORDS_W) begin
            sum = sum - NWORDS_W;
        end else begin
            sum = sum;
        end
        return sum[AW-1:0];
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] base_r;
    logic [AW:0]   len_r;
    logic [AW:0]   i_r;
    logic [AW:0]   j_r;
    logic          inflight_r;
    logic          busy_r;
    logic          done_r;
    logic          s_ready_r;
    logic [AW-1:0] addr_s;
    logic          wr_acc_s;
    logic          issue_s;
    logic          pop_s;
    logic          space_s;

    assign addr_s   = wrap_addr(base_r, i_r);
    assign wr_acc_s = (state_r == ST_WR) && s_valid && s_ready_r;
    assign issue_s  = (state_r == ST_RD) && (i_r < len_r) && space_s;

    assign cpu_busy = busy_r;
    assign done     = done_r;
    assign s_ready  = s_ready_r;

    mem_dma_obuf #(.NBDATA(NBDATA)) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (mem_data_out),
        .inflight  (inflight_r),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .space     (space_s),
        .pop       (pop_s)
    );

    // Next-state logic; the last word is the one whose index equals len-1.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = (dir == DIR_RD) ? ST_RD : ST_WR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if (wr_acc_s && (i_r == len_r - ONE_W)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_RD: begin
                if (pop_s && (j_r == len_r - ONE_W)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Memory port steering: processor pass-through only while idle.
    always_comb begin
        mem_wr      = 1'b0;
        mem_addr_w  = addr_s;
        mem_addr_r  = cpu_addr_r;
        mem_data_in = s_data;
        case (state_r)
            ST_IDLE: begin
                mem_wr      = cpu_wr;
                mem_addr_w  = cpu_addr_w;
                mem_data_in = cpu_data_in;
            end
            ST_WR:   mem_wr = wr_acc_s;
            ST_RD:   mem_addr_r = addr_s;
            default: mem_wr = 1'b0;
        endcase
    end

    // State, handshake flags and transfer counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            s_ready_r  <= 1'b0;
            base_r     <= '0;
            len_r      <= '0;
            i_r        <= '0;
            j_r        <= '0;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE) || (state_r == ST_DONE);
            done_r     <= (state_nxt_s == ST_DONE);
            s_ready_r  <= (state_nxt_s == ST_WR);
            inflight_r <= issue_s;
            if (state_r == ST_IDLE) begin
                if (start) begin
                    base_r <= base;
                    len_r  <= len;
                end
                i_r <= '0;
                j_r <= '0;
            end else begin
                if (wr_acc_s || issue_s) begin
                    i_r <= i_r + ONE_W;
                end
                if (pop_s) begin
                    j_r <= j_r + ONE_W;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with an attached behavioural RAM, expected-write
// and expected-read scoreboards, and literal checks that pin the model.
module tb_mem_dma;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr_w;
    logic [AW-1:0] cpu_addr_r;
    logic [DW-1:0] cpu_data_in;
    logic          cpu_busy;
    logic          start;
    logic          dir;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          done;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_addr_w;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    logic [DW-1:0] mem [N];
    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    int            n_checks = 0;
    int            n_errs   = 0;
    int            busy_cnt = 0;
    int            done_cnt = 0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    int            rdy_pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};

    mem_dma #(.NADDRE(N), .NBDATA(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_wr(cpu_wr), .cpu_addr_w(cpu_addr_w), .cpu_addr_r(cpu_addr_r),
        .cpu_data_in(cpu_data_in), .cpu_busy(cpu_busy),
        .start(start), .dir(dir), .base(base), .len(len), .done(done),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .mem_wr(mem_wr), .mem_addr_w(mem_addr_w), .mem_addr_r(mem_addr_r),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr_w] <= mem_data_in;
        mem_data_out <= mem[mem_addr_r];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: every engine write and every stream-out word against the scoreboards.
    always @(negedge clk) begin
        if (cpu_busy) busy_cnt++;
        if (done) done_cnt++;
        if (mem_wr && !cpu_wr) begin
            if (wq.size() == 0) begin
                chk("dma_wr_spurious", {31'd0, mem_wr}, 32'd0);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("dma_wr_addr", {29'd0, mem_addr_w}, {29'd0, e.a});
                chk("dma_wr_data", mem_data_in, e.d);
            end
        end
        if (m_valid && rq.size() == 0) begin
            chk("mvalid_spurious", {31'd0, m_valid}, 32'd0);
        end else if (m_valid && m_ready) begin
            chk("rd_data", m_data, rq.pop_front());
        end
        if (hold_v && !rst) begin
            chk("rd_hold_valid", {31'd0, m_valid}, 32'd1);
            chk("rd_hold_data", m_data, hold_d);
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic d, input int b, input int l);
        start = 1'b1;
        dir   = d;
        base  = 3'(b);
        len   = 4'(l);
        step();
        start = 1'b0;
    endtask

    task automatic exp_wr(input int b, input int l, input logic [DW-1:0] d0);
        for (int i = 0; i < l; i++) begin
            wr_t e;
            e.a = 3'((b + i) % N);
            e.d = d0 + 32'(i);
            wq.push_back(e);
        end
    endtask

    task automatic exp_rd(input int b, input int l);
        for (int i = 0; i < l; i++) rq.push_back(mem[(b + i) % N]);
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_hs", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cpu_wr = 1'b0; cpu_addr_w = '0; cpu_addr_r = '0; cpu_data_in = '0;
        start = 1'b0; dir = 1'b0; base = '0; len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_busy",    {31'd0, cpu_busy}, 32'd0);
        chk("rst_done",    {31'd0, done},     32'd0);
        chk("rst_s_ready", {31'd0, s_ready},  32'd0);
        chk("rst_m_valid", {31'd0, m_valid},  32'd0);
        chk("rst_m_data",  m_data,            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Processor pass-through in IDLE
        cpu_wr = 1'b1; cpu_addr_w = 3'd3; cpu_data_in = 32'h55; cpu_addr_r = 3'd5;
        #1;
        chk("pt_mem_wr",   {31'd0, mem_wr},     32'd1);
        chk("pt_addr_w",   {29'd0, mem_addr_w}, 32'd3);
        chk("pt_data_in",  mem_data_in,         32'h55);
        chk("pt_addr_r",   {29'd0, mem_addr_r}, 32'd5);
        chk("pt_busy",     {31'd0, cpu_busy},   32'd0);
        step();
        chk("pt_mem3", mem[3], 32'h55);
        for (int k = 0; k < N; k++) begin
            cpu_addr_w = 3'(k);
            cpu_data_in = 32'h10 + 32'(k);
            step();
        end
        cpu_wr = 1'b0;

        // WRITE base 6 len 4, wrapping
        busy_cnt = 0; done_cnt = 0;
        exp_wr(6, 4, 32'hA0);
        go(1'b0, 6, 4);
        for (int i = 0; i < 4; i++) send_word(32'hA0 + 32'(i));
        @(negedge clk);
        chk("wr_done_pulse", {31'd0, done},    32'd1);
        chk("wr_sready_off", {31'd0, s_ready}, 32'd0);
        step(); step(); step();
        chk("wr_busy_cycles", 32'(busy_cnt), 32'd6);
        chk("wr_done_count",  32'(done_cnt), 32'd1);
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);
        chk("wr_mem6", mem[6], 32'hA0);
        chk("wr_mem7", mem[7], 32'hA1);
        chk("wr_mem0", mem[0], 32'hA2);
        chk("wr_mem1", mem[1], 32'hA3);

        // READ base 2 len 3, m_ready high
        done_cnt = 0;
        m_ready = 1'b1;
        exp_rd(2, 3);
        go(1'b1, 2, 3);
        @(negedge clk); chk("rd_lat1", {31'd0, m_valid}, 32'd0);
        @(negedge clk); chk("rd_lat2", {31'd0, m_valid}, 32'd0);
        @(negedge clk); chk("rd_first_valid", {31'd0, m_valid}, 32'd1); chk("rd_w0", m_data, 32'h12);
        @(negedge clk); chk("rd_w1", m_data, 32'h13);
        @(negedge clk); chk("rd_w2", m_data, 32'h14);
        @(negedge clk); chk("rd_done", {31'd0, done}, 32'd1); chk("rd_valid_off", {31'd0, m_valid}, 32'd0);
        step();
        chk("rd_done_count", 32'(done_cnt), 32'd1);
        chk("rd_queue_empty", 32'(rq.size()), 32'd0);
        m_ready = 1'b0;

        // READ base 6 len 5 under backpressure
        done_cnt = 0;
        exp_rd(6, 5);
        go(1'b1, 6, 5);
        for (int k = 0; k < 60 && done_cnt == 0; k++) begin
            m_ready = (k < 12) ? rdy_pat[k][0] : 1'b1;
            step();
        end
        m_ready = 1'b0;
        step();
        chk("bp_done_count", 32'(done_cnt), 32'd1);
        chk("bp_queue_empty", 32'(rq.size()), 32'd0);

        // len = 0 completes at once with no stream activity
        done_cnt = 0;
        s_valid = 1'b1; s_data = 32'hEE;
        go(1'b0, 5, 0);
        @(negedge clk);
        chk("len0_done",   {31'd0, done},    32'd1);
        chk("len0_sready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        step(); step();
        chk("len0_done_count", 32'(done_cnt), 32'd1);

        // start while busy is ignored
        done_cnt = 0;
        exp_wr(4, 2, 32'hC0);
        go(1'b0, 4, 2);
        send_word(32'hC0);
        start = 1'b1; dir = 1'b1; base = 3'd0; len = 4'd3;
        send_word(32'hC1);
        start = 1'b0;
        wait_done(10);
        step(); step();
        chk("ign_done_count", 32'(done_cnt), 32'd1);
        chk("ign_queue_empty", 32'(wq.size()), 32'd0);
        chk("ign_mem4", mem[4], 32'hC0);
        chk("ign_mem5", mem[5], 32'hC1);

        // reset mid-write after two of four words
        done_cnt = 0;
        exp_wr(0, 4, 32'hD0);
        go(1'b0, 0, 4);
        send_word(32'hD0);
        send_word(32'hD1);
        wq.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_valid = 1'b1; s_data = 32'hDD;
        cpu_wr = 1'b1; cpu_addr_w = 3'd7; cpu_data_in = 32'h77;
        #1;
        chk("rrst_mem_wr",  {31'd0, mem_wr},     32'd1);
        chk("rrst_addr_w",  {29'd0, mem_addr_w}, 32'd7);
        chk("rrst_data_in", mem_data_in,         32'h77);
        chk("rrst_busy",    {31'd0, cpu_busy},   32'd0);
        chk("rrst_sready",  {31'd0, s_ready},    32'd0);
        step();
        cpu_wr = 1'b0;
        step(); step(); step();
        s_valid = 1'b0;
        chk("rrst_mem7", mem[7], 32'h77);
        chk("rrst_mem0", mem[0], 32'hD0);
        chk("rrst_mem1", mem[1], 32'hD1);
        chk("rrst_mem2", mem[2], 32'h12);
        chk("rrst_no_done", 32'(done_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
